// File: rtl/spi_shift_register.sv
// Purpose: SPI frame shift register with parallel load, serial in/out and frame-complete pulse.
// Latency: one shift per ce-qualified edge; pdata_out/done update on the edge completing WIDTH shifts.
// Backpressure: none; ce qualifies each shift and the block never stalls its source.
module spi_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pdata_in,
  input  logic                     sin,
  output logic                     sout,
  output logic [WIDTH-1:0]         pdata_out,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // A one-bit frame has no meaningful shift direction; refuse to elaborate it.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("spi_shift_register: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             shift_en;
  logic             last_shift;

  // Next shift-register value for a shift, direction fixed at elaboration.
  generate
    if (LSB_FIRST) begin : g_lsb
      always_comb shifted = {sin, shreg[WIDTH-1:1]};
      assign sout = shreg[0];
    end else begin : g_msb
      always_comb shifted = {shreg[WIDTH-2:0], sin};
      assign sout = shreg[WIDTH-1];
    end
  endgenerate

  // load outranks ce, so a coincident load swallows the shift (and any completion).
  assign shift_en   = ce && !load;
  // Idle has bit_cnt == 0, so this only fires on the final shift of a live frame.
  assign last_shift = (bit_cnt == LAST);

  // Data path: parallel load or serial shift; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= pdata_in;
    end else if (ce) begin
      shreg <= shifted;
    end
  end

  // Frame control: counting, busy tracking, capture of the received word and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pdata_out <= '0;
    end else if (load) begin
      // Frame start; also aborts a frame in flight without reporting it.
      bit_cnt <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (shift_en) begin
      if (last_shift) begin
        bit_cnt   <= '0;
        busy      <= 1'b0;
        done      <= 1'b1;
        pdata_out <= shifted;
      end else if (!busy) begin
        // Receive-only frame started by the first strobe, no load needed.
        bit_cnt <= CW'(1);
        busy    <= 1'b1;
        done    <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        done    <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed bench for spi_shift_register: MSB- and LSB-first instances share stimulus;
// expected serial-out bits and received words go into queues when driven and are
// checked when the DUT shifts or pulses done.
module tb_spi_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       load;
  logic [7:0] pdata_in;
  logic       sin;

  logic       sout_m, busy_m, done_m;
  logic [7:0] pdo_m;
  logic [2:0] cnt_m;
  logic       sout_l, busy_l, done_l;
  logic [7:0] pdo_l;
  logic [2:0] cnt_l;

  logic       sel;
  logic       so, bz, dn;
  logic [7:0] pdo;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_err    = 0;

  logic       sout_q [$];
  logic [7:0] frame_q [$];

  always #5 clk = ~clk;

  spi_shift_register #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .pdata_in(pdata_in), .sin(sin),
    .sout(sout_m), .pdata_out(pdo_m), .bit_cnt(cnt_m), .busy(busy_m), .done(done_m)
  );

  spi_shift_register #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .pdata_in(pdata_in), .sin(sin),
    .sout(sout_l), .pdata_out(pdo_l), .bit_cnt(cnt_l), .busy(busy_l), .done(done_l)
  );

  // Observe whichever instance the current test targets.
  assign so  = sel ? sout_l : sout_m;
  assign bz  = sel ? busy_l : busy_m;
  assign dn  = sel ? done_l : done_m;
  assign pdo = sel ? pdo_l  : pdo_m;
  assign cnt = sel ? cnt_l  : cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check queued sout before a shift, check done after the edge.
  task automatic step(input logic l, input logic c, input logic s,
                      input logic [7:0] pd, input logic exp_done);
    @(negedge clk);
    load = l; ce = c; sin = s; pdata_in = pd;
    #1;
    if (c && !l && sout_q.size() > 0) chk("sout", 32'(so), 32'(sout_q.pop_front()));
    @(posedge clk);
    #1;
    chk("done", 32'(dn), 32'(exp_done));
    if (dn) begin
      chk("frame_pending", 32'(frame_q.size() != 0), 32'd1);
      if (frame_q.size() != 0) chk("pdata_out", 32'(pdo), 32'(frame_q.pop_front()));
    end
  endtask

  // Load a word then shift 8 bits; bit vectors are listed first-bit-at-[7].
  task automatic run_frame(input logic [7:0] pd, input logic [7:0] sin_bits,
                           input logic [7:0] sout_bits, input logic [7:0] exp_pd);
    step(1'b1, 1'b0, 1'b0, pd, 1'b0);
    for (int i = 0; i < 8; i++) sout_q.push_back(sout_bits[7-i]);
    frame_q.push_back(exp_pd);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, sin_bits[7-i], 8'h00, i == 7);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("busy_end", 32'(bz), 32'd0);
    chk("pdata_hold", 32'(pdo), 32'(exp_pd));
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b1; ce = 1'b0; load = 1'b0; pdata_in = 8'h00; sin = 1'b0; sel = 1'b0;
    #12;
    // Reset state on both instances.
    chk("rst_sout_m", 32'(sout_m), 0); chk("rst_pdo_m", 32'(pdo_m), 0);
    chk("rst_cnt_m", 32'(cnt_m), 0);   chk("rst_busy_m", 32'(busy_m), 0);
    chk("rst_done_m", 32'(done_m), 0); chk("rst_pdo_l", 32'(pdo_l), 0);
    chk("rst_busy_l", 32'(busy_l), 0); chk("rst_sout_l", 32'(sout_l), 0);
    @(negedge clk); rst = 1'b0;

    // MSB-first basic frame.
    run_frame(8'hC4, 8'h3C, 8'hC4, 8'h3C);

    // LSB-first basic frame.
    sel = 1'b1;
    run_frame(8'hC4, 8'b01011010, 8'b00100011, 8'h5A);
    sel = 1'b0;

    // Receive-only frame from idle with ce gaps; sin = 0x5A MSB-first.
    chk("idle_busy", 32'(bz), 0);
    rx = 8'h5A;
    frame_q.push_back(8'h5A);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, rx[7-i], 8'h00, i == 7);
      chk("gap_cnt", 32'(cnt), 32'((i + 1) % 8));
      chk("gap_busy", 32'(bz), 32'(i != 7));
      if (i != 7) for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("gap_cnt_hold", 32'(cnt), 0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("gap_pdo", 32'(pdo), 32'h5A);

    // Abort: load 0xFF, 3 shifts, reload 0x12 then a full frame of zeros.
    step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("abort_cnt_mid", 32'(cnt), 3);
    run_frame(8'h12, 8'h00, 8'h12, 8'h00);

    // Completion collision: 7 shifts then load+ce together.
    step(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h69, 1'b0);
    chk("coll_cnt", 32'(cnt), 0);
    chk("coll_busy", 32'(bz), 1);
    chk("coll_pdo", 32'(pdo), 32'h00);
    // Shift out the reloaded word to confirm shreg took pdata_in.
    for (int i = 0; i < 8; i++) sout_q.push_back(rx[7-i] ^ rx[7-i] ^ ((8'h69 >> (7 - i)) & 1));
    frame_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 8'h00, i == 7);

    // Async reset mid-frame, pdata_out = 0x3C beforehand.
    run_frame(8'hC4, 8'h3C, 8'hC4, 8'h3C);
    step(1'b1, 1'b0, 1'b0, 8'hC4, 1'b0);
    sout_q.push_back(1'b1); sout_q.push_back(1'b1); sout_q.push_back(1'b0); sout_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rx[i], 8'h00, 1'b0);
    chk("pre_rst_pdo", 32'(pdo), 32'h3C);
    @(negedge clk); ce = 1'b0; #2 rst = 1'b1; #1;
    chk("arst_sout", 32'(so), 0);   chk("arst_pdo", 32'(pdo), 0);
    chk("arst_cnt", 32'(cnt), 0);   chk("arst_busy", 32'(bz), 0);
    chk("arst_done", 32'(dn), 0);
    @(negedge clk); rst = 1'b0;
    run_frame(8'hC4, 8'h3C, 8'hC4, 8'h3C);

    chk("sout_q_empty", 32'(sout_q.size()), 0);
    chk("frame_q_empty", 32'(frame_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
